// File: rtl/rotate_pkg.sv
// rotate_pkg: operation encoding shared by the rotate/shift pipeline
package rotate_pkg;
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_ROR = 2'b01,
    OP_SHL = 2'b10,
    OP_SHR = 2'b11
  } op_t;
endpackage

// File: rtl/rotate_stage.sv
// rotate_stage: combinational move by 2^I in the op's direction when en is set
module rotate_stage
  import rotate_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int I = 0
) (
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  input  op_t              op,
  output logic [WIDTH-1:0] y
);
  localparam int S = 1 << I;
  always_comb
    y = !en ? x :
        op == OP_ROL ? {x[WIDTH-1-S:0], x[WIDTH-1:WIDTH-S]} :
        op == OP_ROR ? {x[S-1:0], x[WIDTH-1:S]} :
        op == OP_SHL ? {x[WIDTH-1-S:0], {S{1'b0}}} :
                       {{S{1'b0}}, x[WIDTH-1:S]};
endmodule

// File: rtl/rotate_pipe.sv
// rotate_pipe: pipelined barrel rotate/shift, one amount bit per stage, valid/ready with bubble collapse
module rotate_pipe
  import rotate_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int KW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [KW-1:0]    amt;
    op_t              op;
  } beat_t;
  beat_t st [KW];
  beat_t nx [KW];
  logic [KW-1:0] v;
  logic [KW-1:0] rdy;
  logic [KW-1:0] vin;
  logic unused_tail;
  assign vin = {v[KW-2:0], in_valid};
  for (genvar g = 0; g < KW; g++) begin : g_stage
    beat_t src;
    logic [WIDTH-1:0] y;
    if (g == 0) begin : g_in
      assign src = '{data: x, amt: k, op: op_t'(op)};
    end else begin : g_mid
      assign src = st[g-1];
    end
    // stage g may load whenever some stage at or after it can make room
    assign rdy[g] = out_ready | ~&v[KW-1:g];
    rotate_stage #(.WIDTH(WIDTH), .I(g)) u_stage (
      .x (src.data),
      .en(src.amt[g]),
      .op(src.op),
      .y (y)
    );
    assign nx[g] = '{data: y, amt: src.amt, op: src.op};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < KW; i++) st[i] <= '0;
    end else if (flush) v <= '0;
    else
      for (int i = 0; i < KW; i++)
        if (rdy[i]) begin
          v[i]  <= vin[i];
          st[i] <= nx[i];
        end
  assign in_ready    = rdy[0];
  assign out_valid   = v[KW-1];
  assign o           = st[KW-1].data;
  assign unused_tail = ^{st[KW-1].amt, st[KW-1].op};
endmodule

// File: tb/tb_rotate_pipe.sv
// tb_rotate_pipe: random and directed checks of rotate_pipe at WIDTH=32 and WIDTH=8 against an arithmetic model
module tb_rotate_pipe;
  logic clk = 0, rst_n = 0, flush = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] x = 0, o;
  logic [4:0] k = 0;
  logic [1:0] op = 0;
  logic in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 1;
  logic [7:0] x8 = 0, o8;
  logic [2:0] k8 = 0;
  logic [1:0] op8 = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q[$];
  logic hold_prev = 0;
  logic [31:0] held_o = 0;

  always #5 clk = ~clk;

  rotate_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .k(k), .op(op), .out_valid(out_valid), .out_ready(out_ready), .o(o));
  rotate_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .k(k8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8), .o(o8));

  function automatic logic [31:0] model(logic [31:0] xi, int ki, int opi, int w);
    logic [63:0] m, xx, r;
    m  = (64'd1 << w) - 1;
    xx = {32'd0, xi} & m;
    case (opi)
      0:       r = (xx << ki) | (xx >> (w - ki));
      1:       r = (xx >> ki) | (xx << (w - ki));
      2:       r = xx << ki;
      default: r = xx >> ki;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard: push on accept, pop on emit, both decided just before the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, out_valid}, 1);
        check("hold_o", o, held_o);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", o, 32'hxxxxxxxx);
        else check("stream_o", o, q.pop_front());
      end
      hold_prev = out_valid && !out_ready && !flush;
      held_o = o;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(x, k, op, 32));
    end
  end

  task automatic single(logic [31:0] xi, logic [4:0] ki, logic [1:0] opi, logic [31:0] exp, string nm);
    int lat;
    out_ready = 1; x = xi; k = ki; op = opi; in_valid = 1;
    @(posedge clk); #1 in_valid = 0; lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1 lat++; end
    check({nm, "_o"}, o, exp);
    check({nm, "_lat"}, lat, 5);
    check({nm, "_model"}, model(xi, ki, opi, 32), exp);
    @(posedge clk); #1;
  endtask

  task automatic single8(logic [7:0] xi, logic [2:0] ki, logic [1:0] opi, logic [7:0] exp, string nm);
    int lat;
    x8 = xi; k8 = ki; op8 = opi; in_valid8 = 1;
    @(posedge clk); #1 in_valid8 = 0; lat = 1;
    while (!out_valid8 && lat < 20) begin @(posedge clk); #1 lat++; end
    check({nm, "_o"}, {24'd0, o8}, {24'd0, exp});
    check({nm, "_lat"}, lat, 3);
    @(posedge clk); #1;
  endtask

  task automatic stream(int n, int stall, bit rnd_rdy, output int ne, output int first, output int last);
    int sent, cyc;
    sent = 0; cyc = 0; ne = 0; first = -1; last = -1;
    while ((sent < n || q.size() > 0) && cyc < 2000) begin
      out_ready = cyc < stall ? 1'b0 : rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
      in_valid = sent < n;
      x = $urandom; k = 5'($urandom); op = 2'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (stall > 0 && cyc == stall - 1) begin
        check("bp_in_ready", {31'd0, in_ready}, 0);
        check("bp_accepted", sent, 5);
      end
      if (out_valid && out_ready) begin
        ne++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      @(posedge clk); #1 cyc++;
    end
    in_valid = 0;
    if (cyc >= 2000) check("stream_timeout", 0, 1);
  endtask

  initial begin
    int ne, first, last;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_o", o, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    single(32'hC7, 5'd21, 2'b00, 32'h18E00000, "rol21");
    single(32'hC00000C7, 5'd2, 2'b00, 32'h0000031F, "rol2");
    for (int p = 0; p < 4; p++) single(32'hDEADBEEF, 5'd0, 2'(p), 32'hDEADBEEF, "k0");
    single(32'h1, 5'd1, 2'b01, 32'h80000000, "ror1");
    single(32'h80000000, 5'd31, 2'b11, 32'h1, "shr31");
    single(32'hFFFFFFFF, 5'd4, 2'b10, 32'hFFFFFFF0, "shl4");
    single(32'h00000001, 5'd31, 2'b10, 32'h80000000, "shl31");
    stream(10, 8, 0, ne, first, last);
    check("bp_count", ne, 10);
    stream(40, 0, 1, ne, first, last);
    check("rnd_count", ne, 40);
    stream(100, 0, 0, ne, first, last);
    check("tput_count", ne, 100);
    check("tput_span", last - first, 99);
    // flush with three beats in flight and a beat offered in the same cycle
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; x = $urandom; k = 5'($urandom); op = 2'($urandom);
      @(posedge clk); #1;
    end
    flush = 1; in_valid = 1;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    check("flush_valid", {31'd0, out_valid}, 0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("flush_stale", {31'd0, out_valid}, 0);
    end
    // asynchronous reset with a held result at the output
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; x = 32'hFFFFFFFF; k = 0; op = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("pre_rst_valid", {31'd0, out_valid}, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 0);
    check("async_rst_o", o, 0);
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    single(32'h12345678, 5'd8, 2'b01, 32'h78123456, "post_rst");
    single8(8'h81, 3'd1, 2'b00, 8'h03, "w8_rol");
    for (int p = 0; p < 4; p++)
      for (int kk = 0; kk < 8; kk++) begin
        logic [7:0] xv;
        xv = 8'($urandom);
        single8(xv, 3'(kk), 2'(p), model({24'd0, xv}, kk, p, 8) & 8'hFF, "w8_sweep");
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rotate_pipe.md
Name: rotate_pipe

Overview:
- Parametrised, pipelined barrel rotator/shifter; successor to the single-cycle combinational 32-bit left rotator.
- Adds WIDTH generalisation, four operations (rotate left/right, logical shift left/right) and a registered pipeline.
- Uses a valid/ready handshake with bubble collapse and a synchronous flush.
- Sits in the datapath wherever a full-rate rotate/shift unit with predictable latency is needed, such as hash rounds and bit-field extraction.

Parameters:
- WIDTH, 32, data width in bits; power of two, minimum 4.
- KW, $clog2(WIDTH), amount width and pipeline depth L; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  input operation present.
- in_ready  output  1  stage 0 can accept this cycle.
- x  input  WIDTH  operand.
- k  input  KW  shift/rotate amount, interpreted as k mod WIDTH (natural from width).
- op  input  2  operation: 00 ROL, 01 ROR, 10 SHL (zero fill), 11 SHR (logical, zero fill).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- o  output  WIDTH  result.

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low clears every stage valid bit immediately, regardless of clk.
  - Reset values: out_valid=0, o=0. in_ready=1 once rst_n is high.
  - Data registers need not reset except the final stage, which resets to 0.
- Pipeline of L = KW stages, numbered 0..L-1. Stage i applies amount bit k[i]:
  - If k[i]=1, the data moves by 2^i in the op's direction.
  - Rotates wrap bits around; shifts fill with zeros.
  - If k[i]=0, the data passes unchanged.
  - Each stage registers data, the remaining k bits, op and valid.
- Latency: a beat accepted on edge N (in_valid & in_ready) drives out_valid=1 with its o after edge N+L-1, i.e. L cycles from presentation to the registered result. WIDTH=32 gives L=5.
- Throughput: one beat per cycle when out_ready stays high.
- Handshake:
  - rdy[L] = out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0]. Stage i loads when rdy[i] is high.
  - Bubble collapse: an empty stage fills even while downstream stalls.
  - Once out_valid is asserted, o and out_valid hold stable until out_ready is high.
  - The producer may change x/k/op freely while in_valid=0.
- Results are exact: ROL by 0 or ROR by 0 returns x. SHL/SHR by WIDTH-1 keeps one bit. No amount equal to WIDTH is representable.
- flush=1 clears all valid bits on the next edge and ignores any in_valid that cycle (in_ready may read high, but the beat is dropped). flush has priority over every load.
- Simultaneous accept-in and emit-out in the same cycle are legal at full depth; no beat is lost or duplicated.
- Reset mid-operation discards all in-flight beats; the first beat after release sees latency L.
- Beat order is strictly preserved.

Decomposition:
- Shared package rotate_pkg:
  - op encoding constants: OP_ROL=2'b00, OP_ROR=2'b01, OP_SHL=2'b10, OP_SHR=2'b11.
  - A struct for the per-stage payload: data, amount, op.
- One natural sub-module, rotate_stage, parametrised by WIDTH and level index I. It is combinational: it moves by 2^I per op when its enable bit is set.
- The top level generates L instances of rotate_stage plus the valid/ready register chain.

Test Plan:
- WIDTH=32, ROL: x=32'hC7, k=21 -> o=32'h18E00000; x=32'hC00000C7, k=2 -> o=32'h0000031F; out_valid rises exactly 5 cycles after acceptance.
- k=0 for all four ops, x=32'hDEADBEEF -> o=32'hDEADBEEF. ROR x=1, k=1 -> 32'h80000000. SHR x=32'h80000000, k=31 -> 1. SHL x=32'hFFFFFFFF, k=4 -> 32'hFFFFFFF0.
- Back-pressure:
  - Stream 10 random beats with out_ready low for 8 cycles. in_ready falls after 5 beats fill the pipe.
  - o holds stable while out_valid and !out_ready.
  - Every result matches the reference model, in order, with no drops or duplicates.
- Full throughput: 100 back-to-back beats with out_ready=1 -> 100 results on 100 consecutive cycles after the first result.
- flush with 3 beats in flight plus in_valid=1 that cycle -> out_valid=0 on the next cycle and no stale results afterwards. rst_n pulsed low mid-stream (asynchronously, between edges) -> out_valid and o drop to 0 immediately.
- WIDTH=8 build: ROL x=8'h81, k=1 -> 8'h03 with latency 3; sweep every k 0..7 against the model for all ops.
